// File: rtl/calc_1_pkg.sv
// Shared types, opcodes, response codes and the combinational ALU for calc_1.
// Vectors are MSB-first ([0:N-1]); bit 0 is the most significant bit.
package calc_1_pkg;

  localparam int DATA_W = 32;
  localparam int CMD_W  = 4;
  localparam int RESP_W = 2;
  localparam int SHAMT_W = 5;

  typedef logic [0:DATA_W-1] data_t;
  typedef logic [0:CMD_W-1]  cmd_t;
  typedef logic [0:RESP_W-1] resp_t;

  localparam cmd_t CMD_NOP = 4'd0;
  localparam cmd_t CMD_ADD = 4'd1;
  localparam cmd_t CMD_SUB = 4'd2;
  localparam cmd_t CMD_SHL = 4'd5;
  localparam cmd_t CMD_SHR = 4'd6;

  localparam resp_t RESP_NONE = 2'd0;
  localparam resp_t RESP_OK   = 2'd1;
  localparam resp_t RESP_OVF  = 2'd2;
  localparam resp_t RESP_INV  = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OP2  = 1'b1
  } state_e;

  typedef struct packed {
    resp_t resp;
    data_t data;
  } result_t;

  // Data is forced to zero for every response other than RESP_OK.
  function automatic result_t alu(input cmd_t cmd, input data_t a, input data_t b,
                                  input logic shift_en);
    result_t         r;
    logic [0:DATA_W] sum;
    r.resp = RESP_INV;
    r.data = '0;
    sum    = {1'b0, a} + {1'b0, b};
    case (cmd)
      CMD_ADD: begin
        if (sum[0]) begin
          r.resp = RESP_OVF;
        end else begin
          r.resp = RESP_OK;
          r.data = sum[1:DATA_W];
        end
      end
      CMD_SUB: begin
        if (b > a) begin
          r.resp = RESP_OVF;
        end else begin
          r.resp = RESP_OK;
          r.data = a - b;
        end
      end
      CMD_SHL: begin
        if (shift_en) begin
          r.resp = RESP_OK;
          r.data = a << b[DATA_W-SHAMT_W:DATA_W-1];
        end
      end
      CMD_SHR: begin
        if (shift_en) begin
          r.resp = RESP_OK;
          r.data = a >> b[DATA_W-SHAMT_W:DATA_W-1];
        end
      end
      default: begin
        r.resp = RESP_INV;
        r.data = '0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/calc_1_if.sv
// Per-port requester bundle: command/data toward the calculator, response/result back.
interface calc_1_if;
  import calc_1_pkg::*;

  cmd_t  cmd;
  data_t data;
  resp_t resp;
  data_t result;

  modport master (output cmd, output data, input resp, input result);
  modport slave  (input cmd, input data, output resp, output result);

endinterface

// File: rtl/calc_1_port.sv
// One calculator port: two-cycle command capture and registered ALU result.
// Shift opcodes execute only when CALC_1_SHIFT_EN is defined.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | waiting for cmd != 0; captures opcode and operand1
//   ST_OP2  | current data is operand2; result loaded on this edge
module calc_1_port
  import calc_1_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  calc_1_if.slave req
);

`ifdef CALC_1_SHIFT_EN
  localparam logic SHIFT_EN = 1'b1;
`else
  localparam logic SHIFT_EN = 1'b0;
`endif

  state_e  state_q, state_d;
  cmd_t    cmd_q, cmd_d;
  data_t   op1_q, op1_d;
  resp_t   resp_q, resp_d;
  data_t   data_q, data_d;
  result_t alu_res;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    resp_d  = RESP_NONE;
    data_d  = '0;
    alu_res = alu(cmd_q, op1_q, req.data, SHIFT_EN);
    case (state_q)
      ST_IDLE: begin
        if (req.cmd != CMD_NOP) begin
          cmd_d   = req.cmd;
          op1_d   = req.data;
          state_d = ST_OP2;
        end
      end
      ST_OP2: begin
        // The cmd input is a don't-care here; only data is consumed.
        resp_d  = alu_res.resp;
        data_d  = alu_res.data;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_NOP;
      op1_q   <= '0;
      resp_q  <= RESP_NONE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      resp_q  <= resp_d;
      data_q  <= data_d;
    end
  end

  assign req.resp   = resp_q;
  assign req.result = data_q;

endmodule

// File: rtl/calc_1.sv
// Four independent calculator ports sharing one clock and one OR-combined sync reset.
// Optional shift support is selected with CALC_1_SHIFT_EN (see calc_1_port).
module calc_1
  import calc_1_pkg::*;
(
  output data_t      out_data1,
  output data_t      out_data2,
  output data_t      out_data3,
  output data_t      out_data4,
  output resp_t      out_resp1,
  output resp_t      out_resp2,
  output resp_t      out_resp3,
  output resp_t      out_resp4,
  input  logic       c_clk,
  input  cmd_t       req1_cmd_in,
  input  data_t      req1_data_in,
  input  cmd_t       req2_cmd_in,
  input  data_t      req2_data_in,
  input  cmd_t       req3_cmd_in,
  input  data_t      req3_data_in,
  input  cmd_t       req4_cmd_in,
  input  data_t      req4_data_in,
  input  logic [1:7] reset
);

  logic rst;
  assign rst = |reset;

  calc_1_if p1_if ();
  calc_1_if p2_if ();
  calc_1_if p3_if ();
  calc_1_if p4_if ();

  assign p1_if.cmd  = req1_cmd_in;
  assign p1_if.data = req1_data_in;
  assign p2_if.cmd  = req2_cmd_in;
  assign p2_if.data = req2_data_in;
  assign p3_if.cmd  = req3_cmd_in;
  assign p3_if.data = req3_data_in;
  assign p4_if.cmd  = req4_cmd_in;
  assign p4_if.data = req4_data_in;

  calc_1_port u_port1 (.clk(c_clk), .rst(rst), .req(p1_if));
  calc_1_port u_port2 (.clk(c_clk), .rst(rst), .req(p2_if));
  calc_1_port u_port3 (.clk(c_clk), .rst(rst), .req(p3_if));
  calc_1_port u_port4 (.clk(c_clk), .rst(rst), .req(p4_if));

  assign out_data1 = p1_if.result;
  assign out_data2 = p2_if.result;
  assign out_data3 = p3_if.result;
  assign out_data4 = p4_if.result;
  assign out_resp1 = p1_if.resp;
  assign out_resp2 = p2_if.resp;
  assign out_resp3 = p3_if.resp;
  assign out_resp4 = p4_if.resp;

endmodule

// File: tb/tb_calc_1.sv
// Self-checking bench for calc_1: directed boundary cases, reset on every bit,
// and randomized four-port traffic against an arithmetic reference model.
module tb_calc_1;

`ifdef CALC_1_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  always #100 clk = ~clk;

  logic [1:7]  rst_v;
  logic [0:3]  cmd_v [4];
  logic [0:31] dat_v [4];
  logic [0:1]  obs_resp [4];
  logic [0:31] obs_data [4];

  int checks = 0;
  int errors = 0;

  logic [3:0]  tc [4];
  logic [31:0] ta [4];
  logic [31:0] tb_op [4];
  logic [1:0]  exp_resp [4];
  logic [31:0] exp_data [4];

  calc_1_if u_if1 ();
  calc_1_if u_if2 ();
  calc_1_if u_if3 ();
  calc_1_if u_if4 ();

  assign u_if1.cmd  = cmd_v[0];
  assign u_if1.data = dat_v[0];
  assign u_if2.cmd  = cmd_v[1];
  assign u_if2.data = dat_v[1];
  assign u_if3.cmd  = cmd_v[2];
  assign u_if3.data = dat_v[2];
  assign u_if4.cmd  = cmd_v[3];
  assign u_if4.data = dat_v[3];

  assign obs_resp[0] = u_if1.resp;
  assign obs_resp[1] = u_if2.resp;
  assign obs_resp[2] = u_if3.resp;
  assign obs_resp[3] = u_if4.resp;
  assign obs_data[0] = u_if1.result;
  assign obs_data[1] = u_if2.result;
  assign obs_data[2] = u_if3.result;
  assign obs_data[3] = u_if4.result;

  calc_1 dut (
    .out_data1   (u_if1.result),
    .out_data2   (u_if2.result),
    .out_data3   (u_if3.result),
    .out_data4   (u_if4.result),
    .out_resp1   (u_if1.resp),
    .out_resp2   (u_if2.resp),
    .out_resp3   (u_if3.resp),
    .out_resp4   (u_if4.resp),
    .c_clk       (clk),
    .req1_cmd_in (u_if1.cmd),
    .req1_data_in(u_if1.data),
    .req2_cmd_in (u_if2.cmd),
    .req2_data_in(u_if2.data),
    .req3_cmd_in (u_if3.cmd),
    .req3_data_in(u_if3.data),
    .req4_cmd_in (u_if4.cmd),
    .req4_data_in(u_if4.data),
    .reset       (rst_v)
  );

  // Reference: {resp, data} from plain unsigned arithmetic.
  function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    longint unsigned s;
    case (c)
      4'd1: begin
        s = longint'(a) + longint'(b);
        if (s > 64'h0000_0000_FFFF_FFFF) return {2'd2, 32'd0};
        return {2'd1, s[31:0]};
      end
      4'd2: begin
        if (b > a) return {2'd2, 32'd0};
        return {2'd1, a - b};
      end
      4'd5: begin
        if (!SHIFT_EN) return {2'd3, 32'd0};
        return {2'd1, a << (b % 32)};
      end
      4'd6: begin
        if (!SHIFT_EN) return {2'd3, 32'd0};
        return {2'd1, a >> (b % 32)};
      end
      default: return {2'd3, 32'd0};
    endcase
  endfunction

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed resp/data=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_expected(input string tag);
    for (int p = 0; p < 4; p++)
      check($sformatf("%s_p%0d", tag, p + 1), {obs_resp[p], obs_data[p]},
            {exp_resp[p], exp_data[p]});
  endtask

  task automatic check_zero(input string tag);
    for (int p = 0; p < 4; p++)
      check($sformatf("%s_p%0d", tag, p + 1), {obs_resp[p], obs_data[p]}, 34'd0);
  endtask

  // Called just after a falling edge; drives op1, then op2, then checks the result.
  task automatic run_txn(input string tag, input bit clear_after);
    for (int p = 0; p < 4; p++) begin
      cmd_v[p] = tc[p];
      dat_v[p] = ta[p];
    end
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      cmd_v[p] = (tc[p] == 4'd0) ? 4'd0 : 4'($urandom_range(0, 15));
      dat_v[p] = tb_op[p];
    end
    @(negedge clk);
    check_expected(tag);
    for (int p = 0; p < 4; p++) begin
      cmd_v[p] = 4'd0;
      dat_v[p] = $urandom;
    end
    if (clear_after) begin
      @(negedge clk);
      check_zero({tag, "_clr"});
    end
  endtask

  task automatic p1_txn(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] er, input logic [31:0] ed,
                        input bit clr);
    for (int p = 0; p < 4; p++) begin
      tc[p] = 4'd0; ta[p] = $urandom; tb_op[p] = $urandom;
      exp_resp[p] = 2'd0; exp_data[p] = 32'd0;
    end
    tc[0] = c; ta[0] = a; tb_op[0] = b; exp_resp[0] = er; exp_data[0] = ed;
    run_txn(tag, clr);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 20));
      1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_v = 7'b100_0000;
    for (int p = 0; p < 4; p++) begin
      cmd_v[p] = 4'd0;
      dat_v[p] = 32'd0;
    end
    repeat (4) @(negedge clk);
    check_zero("reset1");
    rst_v = '0;

    // Single-port arithmetic and boundaries, alternating back-to-back and idle gaps.
    p1_txn("add_1_1fff",   4'd1, 32'h1, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000, 1'b0);
    p1_txn("add_1fff_x2",  4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE, 1'b1);
    p1_txn("add_0_0",      4'd1, 32'h0, 32'h0, 2'd1, 32'h0, 1'b0);
    p1_txn("add_ovf",      4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'h0, 1'b1);
    p1_txn("sub_1_f",      4'd2, 32'h1, 32'hF, 2'd2, 32'h0, 1'b0);
    p1_txn("sub_9_4",      4'd2, 32'h9, 32'h4, 2'd1, 32'h5, 1'b1);
    p1_txn("sub_x_x",      4'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'd1, 32'h0, 1'b0);
    p1_txn("cmd3",         4'd3, 32'h1, 32'h0, 2'd3, 32'h0, 1'b1);
    p1_txn("cmd4",         4'd4, 32'h1, 32'h0, 2'd3, 32'h0, 1'b1);
    p1_txn("cmd15",        4'd15, 32'h7, 32'h7, 2'd3, 32'h0, 1'b1);

    // All four ports in the same cycle.
    tc[0] = 4'd1; ta[0] = 32'h2; tb_op[0] = 32'h3; exp_resp[0] = 2'd1; exp_data[0] = 32'h5;
    tc[1] = 4'd2; ta[1] = 32'h7; tb_op[1] = 32'h2; exp_resp[1] = 2'd1; exp_data[1] = 32'h5;
    tc[2] = 4'd5; ta[2] = 32'h1; tb_op[2] = 32'h4;
    tc[3] = 4'd6; ta[3] = 32'h80; tb_op[3] = 32'h0;
    if (SHIFT_EN) begin
      exp_resp[2] = 2'd1; exp_data[2] = 32'h10;
      exp_resp[3] = 2'd1; exp_data[3] = 32'h80;
    end else begin
      exp_resp[2] = 2'd3; exp_data[2] = 32'h0;
      exp_resp[3] = 2'd3; exp_data[3] = 32'h0;
    end
    run_txn("all4", 1'b1);

    // Reset asserted during the operand2 cycle on each bit in turn.
    for (int k = 1; k <= 7; k++) begin
      for (int p = 0; p < 4; p++) begin
        cmd_v[p] = 4'd1;
        dat_v[p] = 32'd1;
      end
      @(negedge clk);
      rst_v    = '0;
      rst_v[k] = 1'b1;
      for (int p = 0; p < 4; p++) begin
        cmd_v[p] = 4'd0;
        dat_v[p] = 32'd2;
      end
      @(negedge clk);
      check_zero($sformatf("rst_op2_b%0d", k));
      rst_v = '0;
      for (int p = 0; p < 4; p++) begin
        tc[p] = 4'd2; ta[p] = 32'd10 + 32'(p); tb_op[p] = 32'd3;
        exp_resp[p] = 2'd1; exp_data[p] = 32'd7 + 32'(p);
      end
      run_txn($sformatf("after_rst_b%0d", k), 1'b1);
    end

    // Randomized traffic on all ports, compared with the reference model.
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < 4; p++) begin
        case ($urandom_range(0, 5))
          0:       tc[p] = 4'd0;
          1:       tc[p] = 4'd1;
          2:       tc[p] = 4'd2;
          3:       tc[p] = 4'd5;
          4:       tc[p] = 4'd6;
          default: tc[p] = 4'($urandom_range(1, 15));
        endcase
        ta[p]    = rand_operand();
        tb_op[p] = rand_operand();
        if (tc[p] == 4'd0) begin
          exp_resp[p] = 2'd0;
          exp_data[p] = 32'd0;
        end else begin
          {exp_resp[p], exp_data[p]} = model(tc[p], ta[p], tb_op[p]);
        end
      end
      run_txn($sformatf("rand%0d", it), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    check_zero("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
